// File: rtl/me_stage_if.sv
// Handshake and data buses around the ME stage: EX->ME handoff, data-SRAM read
// data, ME->WB handoff and the ID forwarding outputs.
interface me_stage_if;
  logic        ex_valid;
  logic [70:0] ex_to_me_bus;
  logic        me_ready;
  logic [31:0] data_sram_rdata;
  logic        me_valid;
  logic        wb_ready;
  logic [69:0] me_to_wb_bus;
  logic [37:0] me_fwd_bus;
  logic        me_is_load;

  modport master (
    output ex_valid, ex_to_me_bus, data_sram_rdata, wb_ready,
    input  me_ready, me_valid, me_to_wb_bus, me_fwd_bus, me_is_load
  );

  modport slave (
    input  ex_valid, ex_to_me_bus, data_sram_rdata, wb_ready,
    output me_ready, me_valid, me_to_wb_bus, me_fwd_bus, me_is_load
  );
endinterface

// File: rtl/me_stage.sv
// Memory-access pipeline stage: registers the EX result bus, merges data-SRAM
// read data for loads (buffered across WB stalls) and drives the ID forwarding bus.
module me_stage (
  input  logic       clk,
  input  logic       reset,
  me_stage_if.slave  me_if
);

  logic        valid_r;
  logic        first_r;
  logic        buf_vld;
  logic [70:0] bus_r;
  logic [31:0] rdata_buf;

  logic [31:0] pc;
  logic [31:0] alu_result;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        ready;

  assign pc           = bus_r[70:39];
  assign alu_result   = bus_r[38:7];
  assign res_from_mem = bus_r[6];
  assign gr_we        = bus_r[5];
  assign dest         = bus_r[4:0];

  assign ready = reset && (!valid_r || me_if.wb_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_r   <= 1'b0;
      first_r   <= 1'b0;
      buf_vld   <= 1'b0;
      bus_r     <= '0;
      rdata_buf <= '0;
    end else if (ready) begin
      // Either the old instruction leaves or a new one arrives: buffer is stale.
      valid_r <= me_if.ex_valid;
      buf_vld <= 1'b0;
      if (me_if.ex_valid) begin
        bus_r   <= me_if.ex_to_me_bus;
        first_r <= 1'b1;
      end
    end else begin
      first_r <= 1'b0;
      // SRAM data is only valid in the first ME cycle; hold it while WB stalls.
      if (valid_r && first_r && res_from_mem) begin
        rdata_buf <= me_if.data_sram_rdata;
        buf_vld   <= 1'b1;
      end
    end
  end

  assign load_data    = buf_vld ? rdata_buf : me_if.data_sram_rdata;
  assign final_result = res_from_mem ? load_data : alu_result;

  assign me_if.me_ready     = ready;
  assign me_if.me_valid     = valid_r;
  assign me_if.me_to_wb_bus = {pc, final_result, gr_we, dest};
  assign me_if.me_fwd_bus   = {valid_r && gr_we && (dest != 5'd0), dest, final_result};
  assign me_if.me_is_load   = valid_r && res_from_mem;

endmodule

// File: tb/tb_me_stage.sv
// Scoreboard bench for me_stage: expected WB bus words are queued on EX handoff
// and compared when ME hands off to WB; direct checks cover forwarding and stalls.
module tb_me_stage;
  logic clk = 1'b0;
  logic reset;

  me_stage_if mif ();

  me_stage dut (
    .clk   (clk),
    .reset (reset),
    .me_if (mif)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [69:0] sb[$];
  logic [31:0] ld_exp;
  logic [69:0] snap_wb;
  logic [37:0] snap_fwd;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [70:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                     input logic rfm, input logic we, input logic [4:0] dst);
    return {pc, alu, rfm, we, dst};
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs only change just after posedge, so negedge sees the values the next edge samples.
  always @(negedge clk) begin
    logic [70:0] b;
    if (!reset) begin
      sb.delete();
    end else begin
      if (mif.me_valid && mif.wb_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("wb_bus", mif.me_to_wb_bus, sb.pop_front());
      end
      if (mif.ex_valid && mif.me_ready) begin
        b = mif.ex_to_me_bus;
        sb.push_back({b[70:39], (b[6] ? ld_exp : b[38:7]), b[5], b[4:0]});
      end
    end
  end

  initial begin
    reset = 1'b0;
    mif.ex_valid = 1'b1;
    mif.ex_to_me_bus = mk(32'h1c00_0000, 32'h1111_1111, 1'b0, 1'b1, 5'd9);
    mif.wb_ready = 1'b1;
    mif.data_sram_rdata = '0;
    ld_exp = '0;

    // Reset held with EX offering an instruction
    repeat (3) begin
      cyc(1);
      chk("rst_valid", mif.me_valid, 0);
      chk("rst_ready", mif.me_ready, 0);
      chk("rst_fwd_we", mif.me_fwd_bus[37], 0);
      chk("rst_is_load", mif.me_is_load, 0);
      chk("rst_bus", {mif.me_to_wb_bus[69:38], mif.me_to_wb_bus[5:0]}, 0);
    end
    reset = 1'b1;
    mif.ex_valid = 1'b0;
    #1;
    chk("rel_ready", mif.me_ready, 1);
    cyc(1);

    // Back-to-back ALU instructions
    for (int i = 0; i < 4; i++) begin
      mif.ex_valid = 1'b1;
      mif.ex_to_me_bus = mk(32'h1c00_0100 + 32'(4 * i), 32'(16 * (i + 1)), 1'b0, 1'b1, 5'(i + 1));
      cyc(1);
      chk("b2b_valid", mif.me_valid, 1);
      chk("b2b_fwd", mif.me_fwd_bus, {1'b1, 5'(i + 1), 32'(16 * (i + 1))});
    end
    mif.ex_valid = 1'b0;
    cyc(1);
    chk("drain_valid", mif.me_valid, 0);

    // Load with no stall
    mif.ex_valid = 1'b1;
    mif.ex_to_me_bus = mk(32'h1c00_0200, 32'h0000_0055, 1'b1, 1'b1, 5'd5);
    ld_exp = 32'hDEAD_BEEF;
    cyc(1);
    mif.ex_valid = 1'b0;
    mif.data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_result", mif.me_to_wb_bus[37:6], 32'hDEAD_BEEF);
    chk("ld_is_load", mif.me_is_load, 1);
    chk("ld_fwd", mif.me_fwd_bus, {1'b1, 5'd5, 32'hDEAD_BEEF});
    cyc(1);
    chk("ld_drain_is_load", mif.me_is_load, 0);

    // Load held by a three-cycle WB stall; SRAM data changes after the first ME cycle
    mif.ex_valid = 1'b1;
    mif.ex_to_me_bus = mk(32'h1c00_0300, 32'h0000_0066, 1'b1, 1'b1, 5'd6);
    ld_exp = 32'hCAFE_F00D;
    cyc(1);
    mif.ex_valid = 1'b0;
    mif.data_sram_rdata = 32'hCAFE_F00D;
    mif.wb_ready = 1'b0;
    #1;
    chk("stall_result0", mif.me_to_wb_bus[37:6], 32'hCAFE_F00D);
    chk("stall_ready0", mif.me_ready, 0);
    snap_wb = mif.me_to_wb_bus;
    snap_fwd = mif.me_fwd_bus;
    cyc(1);
    mif.data_sram_rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("stall_result", mif.me_to_wb_bus[37:6], 32'hCAFE_F00D);
      chk("stall_ready", mif.me_ready, 0);
      chk("stall_wb_stable", mif.me_to_wb_bus, snap_wb);
      chk("stall_fwd_stable", mif.me_fwd_bus, snap_fwd);
      cyc(1);
    end
    mif.wb_ready = 1'b1;
    #1;
    chk("stall_release_result", mif.me_to_wb_bus[37:6], 32'hCAFE_F00D);
    cyc(1);
    chk("stall_drain_valid", mif.me_valid, 0);

    // Write to r0 must not forward
    mif.ex_valid = 1'b1;
    mif.ex_to_me_bus = mk(32'h1c00_0400, 32'h0000_0077, 1'b0, 1'b1, 5'd0);
    cyc(1);
    mif.ex_valid = 1'b0;
    chk("r0_fwd_we", mif.me_fwd_bus[37], 0);
    chk("r0_gr_we", mif.me_to_wb_bus[5], 1);
    cyc(1);

    // Stalled load discarded by reset; later instructions see no stale buffer
    mif.ex_valid = 1'b1;
    mif.ex_to_me_bus = mk(32'h1c00_0500, 32'h0000_0088, 1'b1, 1'b1, 5'd7);
    ld_exp = 32'hA5A5_A5A5;
    cyc(1);
    mif.ex_valid = 1'b0;
    mif.data_sram_rdata = 32'hA5A5_A5A5;
    mif.wb_ready = 1'b0;
    cyc(1);
    mif.data_sram_rdata = '0;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    mif.wb_ready = 1'b1;
    #1;
    chk("rst_stall_valid", mif.me_valid, 0);
    chk("rst_stall_ready", mif.me_ready, 1);
    mif.ex_valid = 1'b1;
    mif.ex_to_me_bus = mk(32'h1c00_0600, 32'h0000_0099, 1'b0, 1'b1, 5'd8);
    cyc(1);
    mif.ex_to_me_bus = mk(32'h1c00_0604, 32'h0000_00aa, 1'b1, 1'b1, 5'd9);
    ld_exp = 32'h3C3C_3C3C;
    mif.data_sram_rdata = 32'h0BAD_F00D;
    #1;
    chk("post_rst_alu", mif.me_to_wb_bus[37:6], 32'h0000_0099);
    cyc(1);
    mif.ex_valid = 1'b0;
    mif.data_sram_rdata = 32'h3C3C_3C3C;
    #1;
    chk("post_rst_load", mif.me_to_wb_bus[37:6], 32'h3C3C_3C3C);
    cyc(2);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
